// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: holds all domain resets, waits for PLL lock, then releases
// domains one at a time in index order and re-asserts on lock loss or software request.
module reset_seq_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 8,
  parameter int STEP_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_lock,
  input  logic               sw_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_done,
  output logic [1:0]         rst_cause
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [NUM_DOM-1:0]   dom_rst_n_r, dom_rst_n_s;
  logic                 seq_done_r, seq_done_s;
  logic [1:0]           rst_cause_r, rst_cause_s;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    dom_rst_n_s = dom_rst_n_r;
    seq_done_s  = seq_done_r;
    rst_cause_s = rst_cause_r;

    case (state_r)
      ST_ASSERT: begin
        dom_rst_n_s = {NUM_DOM{1'b0}};
        seq_done_s  = 1'b0;
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (pll_lock) begin
          state_s = ST_RELEASE;
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
        end else begin
          state_s = ST_WAIT_LOCK;
        end
      end

      ST_RELEASE, ST_RUN: begin
        // Lock loss outranks a simultaneous software request.
        if (!pll_lock) begin
          state_s     = ST_ASSERT;
          cnt_s       = {CNT_W{1'b0}};
          dom_rst_n_s = {NUM_DOM{1'b0}};
          seq_done_s  = 1'b0;
          rst_cause_s = CAUSE_LOCK;
        end else if (sw_rst_req) begin
          state_s     = ST_ASSERT;
          cnt_s       = {CNT_W{1'b0}};
          dom_rst_n_s = {NUM_DOM{1'b0}};
          seq_done_s  = 1'b0;
          rst_cause_s = CAUSE_SW;
        end else if (state_r == ST_RELEASE) begin
          if (cnt_r == STEP_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            for (int i = 0; i < NUM_DOM; i++) begin
              dom_rst_n_s[i] = dom_rst_n_r[i] | (idx_r == IDX_W'(i));
            end
            if (idx_r == LAST_IDX) begin
              state_s    = ST_RUN;
              seq_done_s = 1'b1;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s     = ST_ASSERT;
        cnt_s       = {CNT_W{1'b0}};
        idx_s       = {IDX_W{1'b0}};
        dom_rst_n_s = {NUM_DOM{1'b0}};
        seq_done_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= ST_ASSERT;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      dom_rst_n_r <= {NUM_DOM{1'b0}};
      seq_done_r  <= 1'b0;
      rst_cause_r <= CAUSE_POR;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      dom_rst_n_r <= dom_rst_n_s;
      seq_done_r  <= seq_done_s;
      rst_cause_r <= rst_cause_s;
    end
  end

  assign dom_rst_n = dom_rst_n_r;
  assign seq_done  = seq_done_r;
  assign rst_cause = rst_cause_r;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default configuration plus a single-domain,
// single-step configuration, with hand-computed edge timings.
module tb_reset_seq_ctrl;

  logic       sys_clk;
  logic       sys_rst_n, pll_lock, sw_rst_req;
  logic [3:0] dom_rst_n;
  logic       seq_done;
  logic [1:0] rst_cause;

  logic       sys_rst_n_b, pll_lock_b, sw_rst_req_b;
  logic [0:0] dom_rst_n_b;
  logic       seq_done_b;
  logic [1:0] rst_cause_b;

  int n_cmp;
  int n_err;

  reset_seq_ctrl u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .dom_rst_n  (dom_rst_n),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause)
  );

  reset_seq_ctrl #(
    .NUM_DOM  (1),
    .HOLD_CYC (8),
    .STEP_CYC (1),
    .CNT_W    (8)
  ) u_dut_b (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n_b),
    .pll_lock   (pll_lock_b),
    .sw_rst_req (sw_rst_req_b),
    .dom_rst_n  (dom_rst_n_b),
    .seq_done   (seq_done_b),
    .rst_cause  (rst_cause_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] d, input logic sd, input logic [1:0] c);
    check_val({tag, ".dom"},   {4'h0, dom_rst_n}, {4'h0, d});
    check_val({tag, ".done"},  {7'h0, seq_done},  {7'h0, sd});
    check_val({tag, ".cause"}, {6'h0, rst_cause}, {6'h0, c});
  endtask

  task automatic check_b(input string tag, input logic d, input logic sd, input logic [1:0] c);
    check_val({tag, ".dom"},   {7'h0, dom_rst_n_b}, {7'h0, d});
    check_val({tag, ".done"},  {7'h0, seq_done_b},  {7'h0, sd});
    check_val({tag, ".cause"}, {6'h0, rst_cause_b}, {6'h0, c});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sys_rst_n    = 1'b0; pll_lock   = 1'b1; sw_rst_req   = 1'b0;
    sys_rst_n_b  = 1'b0; pll_lock_b = 1'b0; sw_rst_req_b = 1'b0;

    step(3);
    check_a("a_reset", 4'b0000, 1'b0, 2'b00);
    check_b("b_reset", 1'b0, 1'b0, 2'b00);

    // Power-on with lock high: releases at edges 25/41/57/73.
    sys_rst_n = 1'b1;
    step(24); check_a("por_e24", 4'b0000, 1'b0, 2'b00);
    step(1);  check_a("por_e25", 4'b0001, 1'b0, 2'b00);
    step(15); check_a("por_e40", 4'b0001, 1'b0, 2'b00);
    step(1);  check_a("por_e41", 4'b0011, 1'b0, 2'b00);
    step(16); check_a("por_e57", 4'b0111, 1'b0, 2'b00);
    step(15); check_a("por_e72", 4'b0111, 1'b0, 2'b00);
    step(1);  check_a("por_e73", 4'b1111, 1'b1, 2'b00);
    step(5);  check_a("run_hold", 4'b1111, 1'b1, 2'b00);

    // One-cycle lock loss in RUN, then full re-sequence.
    pll_lock = 1'b0;
    step(1);  check_a("lockloss", 4'b0000, 1'b0, 2'b01);
    pll_lock = 1'b1;
    step(24); check_a("reseq_e24", 4'b0000, 1'b0, 2'b01);
    step(1);  check_a("reseq_e25", 4'b0001, 1'b0, 2'b01);
    step(16); check_a("reseq_d1", 4'b0011, 1'b0, 2'b01);

    // Software pulse after two domains are released.
    sw_rst_req = 1'b1;
    step(1);  check_a("sw_rst", 4'b0000, 1'b0, 2'b10);
    sw_rst_req = 1'b0;
    step(24); check_a("sw_reseq_e24", 4'b0000, 1'b0, 2'b10);
    step(1);  check_a("sw_reseq_e25", 4'b0001, 1'b0, 2'b10);
    step(47); check_a("sw_reseq_pre", 4'b0111, 1'b0, 2'b10);
    step(1);  check_a("sw_reseq_done", 4'b1111, 1'b1, 2'b10);

    // Simultaneous lock loss and software request: lock loss wins.
    pll_lock = 1'b0; sw_rst_req = 1'b1;
    step(1);  check_a("both", 4'b0000, 1'b0, 2'b01);
    sw_rst_req = 1'b0;

    // Late lock: enter WAIT_LOCK with lock low, sw ignored there, lock 20 cycles later.
    step(8);  check_a("wait_entry", 4'b0000, 1'b0, 2'b01);
    sw_rst_req = 1'b1;
    step(1);  check_a("wait_sw_ign", 4'b0000, 1'b0, 2'b01);
    sw_rst_req = 1'b0;
    step(19); check_a("wait_long", 4'b0000, 1'b0, 2'b01);
    pll_lock = 1'b1;
    step(1);  check_a("late_t", 4'b0000, 1'b0, 2'b01);
    step(15); check_a("late_t15", 4'b0000, 1'b0, 2'b01);
    step(1);  check_a("late_t16", 4'b0001, 1'b0, 2'b01);

    // sys_rst_n pulse mid-RELEASE, then full power-on sequence.
    step(5);
    sys_rst_n = 1'b0;
    step(1);  check_a("mid_rst", 4'b0000, 1'b0, 2'b00);
    sys_rst_n = 1'b1;
    step(24); check_a("mid_por_e24", 4'b0000, 1'b0, 2'b00);
    step(1);  check_a("mid_por_e25", 4'b0001, 1'b0, 2'b00);

    // Single domain, single step: release one edge after the lock sample.
    sys_rst_n_b = 1'b1;
    step(8);  check_b("b_wait", 1'b0, 1'b0, 2'b00);
    step(3);
    pll_lock_b = 1'b1;
    step(1);  check_b("b_lock_t", 1'b0, 1'b0, 2'b00);
    step(1);  check_b("b_rel", 1'b1, 1'b1, 2'b00);
    pll_lock_b = 1'b0;
    step(1);  check_b("b_lockloss", 1'b0, 1'b0, 2'b01);
    pll_lock_b = 1'b1;
    step(9);  check_b("b_in_release", 1'b0, 1'b0, 2'b01);
    sys_rst_n_b = 1'b0;
    step(1);  check_b("b_mid_rst", 1'b0, 1'b0, 2'b00);
    sys_rst_n_b = 1'b1;
    step(9);  check_b("b_por_t", 1'b0, 1'b0, 2'b00);
    step(1);  check_b("b_por_rel", 1'b1, 1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
